alu_rs: RTL

- Reservation station feeding the integer ALU in the out-of-order core.
- Accepts decoded ALU/branch/address ops from dispatch and holds them until both operands are available.
- Snoops the ALU and LSB result broadcasts to wake up waiting operands.
- Issues at most one ready op per cycle to the ALU as a registered one-cycle `execute` pulse.

---
 rtl/alu_rs_if.sv | 50 +++++
 rtl/alu_rs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_if.sv
// Signals between the ALU reservation station and its neighbours: dispatch, result broadcasts, ALU issue.
// The RS side uses the slave modport and the dispatch/broadcast/ALU side uses master.
interface alu_rs_if #(
    parameter int ROB_ID_WIDTH = 3,
    parameter int OP_WIDTH     = 7,
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32
);
    localparam int TAG_WIDTH = ROB_ID_WIDTH + 1;

    logic                  iss_valid;
    logic [OP_WIDTH-1:0]   iss_type;
    logic [VAL_WIDTH-1:0]  iss_vj;
    logic [VAL_WIDTH-1:0]  iss_vk;
    logic                  iss_qj_busy;
    logic                  iss_qk_busy;
    logic [TAG_WIDTH-1:0]  iss_qj;
    logic [TAG_WIDTH-1:0]  iss_qk;
    logic [TAG_WIDTH-1:0]  iss_entry;
    logic [ADDR_WIDTH-1:0] iss_pc;

    logic                  alu_ready;
    logic [TAG_WIDTH-1:0]  alu_entry;
    logic [VAL_WIDTH-1:0]  alu_val;
    logic                  lsb_ready;
    logic [TAG_WIDTH-1:0]  lsb_entry;
    logic [VAL_WIDTH-1:0]  lsb_val;

    logic                  rs_full;
    logic                  execute;
    logic [OP_WIDTH-1:0]   ex_type;
    logic [VAL_WIDTH-1:0]  ex_val1;
    logic [VAL_WIDTH-1:0]  ex_val2;
    logic [TAG_WIDTH-1:0]  ex_entry;
    logic [ADDR_WIDTH-1:0] ex_pc;

    modport master (
        output iss_valid, iss_type, iss_vj, iss_vk, iss_qj_busy, iss_qk_busy,
               iss_qj, iss_qk, iss_entry, iss_pc,
               alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
        input  rs_full, execute, ex_type, ex_val1, ex_val2, ex_entry, ex_pc
    );

    modport slave (
        input  iss_valid, iss_type, iss_vj, iss_vk, iss_qj_busy, iss_qk_busy,
               iss_qj, iss_qk, iss_entry, iss_pc,
               alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
        output rs_full, execute, ex_type, ex_val1, ex_val2, ex_entry, ex_pc
    );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds dispatched ops until both operands arrive, issues one per cycle.
// Define RS_AGE_SELECT_EN to select the oldest ready entry via an age matrix instead of the lowest index.
module alu_rs #(
    parameter int RS_SIZE      = 8,
    parameter int ROB_ID_WIDTH = 3,
    parameter int OP_WIDTH     = 7,
    parameter int VAL_WIDTH    = 32,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic     clk,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     flush,
    alu_rs_if.slave  bus
);
    localparam int RS_IDX_WIDTH = $clog2(RS_SIZE);
    localparam int TAG_WIDTH    = ROB_ID_WIDTH + 1;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0] val;
    } opnd_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        opnd_t                 j;
        opnd_t                 k;
        logic [TAG_WIDTH-1:0]  entry;
        logic [ADDR_WIDTH-1:0] pc;
    } slot_t;

    logic [RS_SIZE-1:0]      valid;
    slot_t                   slots [RS_SIZE];
    logic [RS_SIZE-1:0]      ready;
    logic                    free_found;
    logic [RS_IDX_WIDTH-1:0] free_idx;
    logic                    sel_found;
    logic [RS_IDX_WIDTH-1:0] sel_idx;
    logic                    rs_full;
    logic                    issue_fire;
    opnd_t                   iss_j;
    opnd_t                   iss_k;

    logic                    execute_q;
    logic [OP_WIDTH-1:0]     ex_type_q;
    logic [VAL_WIDTH-1:0]    ex_val1_q;
    logic [VAL_WIDTH-1:0]    ex_val2_q;
    logic [TAG_WIDTH-1:0]    ex_entry_q;
    logic [ADDR_WIDTH-1:0]   ex_pc_q;

    // ALU broadcast is checked first so it wins if both producers carry the same tag.
    function automatic opnd_t wake(input opnd_t o);
        opnd_t r;
        r = o;
        if (o.busy) begin
            if (bus.alu_ready && o.tag == bus.alu_entry) begin
                r.busy = 1'b0;
                r.val  = bus.alu_val;
            end else if (bus.lsb_ready && o.tag == bus.lsb_entry) begin
                r.busy = 1'b0;
                r.val  = bus.lsb_val;
            end
        end
        return r;
    endfunction

    assign rs_full    = &valid;
    assign issue_fire = bus.iss_valid && !rs_full;
    assign iss_j      = wake('{busy: bus.iss_qj_busy, tag: bus.iss_qj, val: bus.iss_vj});
    assign iss_k      = wake('{busy: bus.iss_qk_busy, tag: bus.iss_qk, val: bus.iss_vk});

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = RS_IDX_WIDTH'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid[i] && !slots[i].j.busy && !slots[i].k.busy;
        end
    end

`ifdef RS_AGE_SELECT_EN
    // older[i][j] set means slot i entered the station before slot j.
    logic [RS_SIZE-1:0] older [RS_SIZE];

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ready[i] && (ready & ~older[i] & ~(RS_SIZE'(1) << i)) == '0) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in || (rdy_in && flush)) begin
            for (int i = 0; i < RS_SIZE; i++) older[i] <= '0;
        end else if (rdy_in) begin
            if (sel_found) older[sel_idx] <= '0;
            if (issue_fire) begin
                for (int j = 0; j < RS_SIZE; j++) begin
                    older[j][free_idx] <= valid[j] && !(sel_found && sel_idx == RS_IDX_WIDTH'(j));
                end
                older[free_idx] <= '0;
            end
        end
    end
`else
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = RS_IDX_WIDTH'(i);
            end
        end
    end
`endif

    // NOTE: state uses <= so the free-slot and select decisions all see pre-edge valid bits.
    always_ff @(posedge clk) begin
        if (rst_in || (rdy_in && flush)) begin
            valid      <= '0;
            execute_q  <= 1'b0;
            ex_type_q  <= '0;
            ex_val1_q  <= '0;
            ex_val2_q  <= '0;
            ex_entry_q <= '0;
            ex_pc_q    <= '0;
        end else if (rdy_in) begin
            execute_q <= sel_found;
            if (sel_found) begin
                valid[sel_idx] <= 1'b0;
                ex_type_q      <= slots[sel_idx].op;
                ex_val1_q      <= slots[sel_idx].j.val;
                ex_val2_q      <= slots[sel_idx].k.val;
                ex_entry_q     <= slots[sel_idx].entry;
                ex_pc_q        <= slots[sel_idx].pc;
            end
            if (issue_fire) valid[free_idx] <= 1'b1;
        end
    end

    // NOTE: the payload array is not reset; a slot's contents only matter while its valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst_in && rdy_in && !flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                slots[i].j <= wake(slots[i].j);
                slots[i].k <= wake(slots[i].k);
            end
            if (issue_fire) begin
                slots[free_idx] <= '{op: bus.iss_type, j: iss_j, k: iss_k,
                                     entry: bus.iss_entry, pc: bus.iss_pc};
            end
        end
    end

    // ROB tags are unique, so two producers never legally broadcast the same tag together.
    tag_collision: assert property (@(posedge clk) disable iff (rst_in)
        !(rdy_in && bus.alu_ready && bus.lsb_ready && bus.alu_entry == bus.lsb_entry));

    assign bus.rs_full  = rs_full;
    assign bus.execute  = execute_q;
    assign bus.ex_type  = ex_type_q;
    assign bus.ex_val1  = ex_val1_q;
    assign bus.ex_val2  = ex_val2_q;
    assign bus.ex_entry = ex_entry_q;
    assign bus.ex_pc    = ex_pc_q;
endmodule
